// File: rtl/frogger_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : frogger_pkg                                               |
// | Brief  : Shared types and constants for the frogger player side    |
// |          and the car lanes.                                        |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
package frogger_pkg;

  // Game-level state of the player controller.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } game_state_t;

  // Playfield geometry shared with the car_move instantiation.
  localparam int ROWS_DEF = 8;
  localparam int N_DEF    = 16;

  // Width of the lives counter; covers the full 1..7 start range.
  localparam int LIVES_W  = 3;

endpackage
`default_nettype wire

// File: rtl/frog_pos.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : frog_pos                                                  |
// | Brief  : Frog position register. Steps one cell per enabled move   |
// |          pulse (up > down > left > right), clamps at the playfield |
// |          edges and can be reloaded to the start cell.              |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
module frog_pos
  import frogger_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int ROWS      = ROWS_DEF,
  parameter int START_COL = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_start,
  input  logic                    move_en,
  input  logic                    up,
  input  logic                    down,
  input  logic                    left,
  input  logic                    right,
  output logic [$clog2(ROWS)-1:0] row,
  output logic [$clog2(N)-1:0]    col
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(N);

  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(N - 1);
  localparam logic [CW-1:0] START_C   = CW'(START_COL);
  localparam logic [RW-1:0] ROW_ONE   = RW'(1);
  localparam logic [CW-1:0] COL_ONE   = CW'(1);

  logic [RW-1:0] w_row_next;
  logic [CW-1:0] w_col_next;

  // Next position: reload wins over a move; one move at most, clamped so
  // that a step past an edge leaves the coordinate unchanged.
  always_comb begin
    w_row_next = row;
    w_col_next = col;
    if (load_start) begin
      w_row_next = '0;
      w_col_next = START_C;
    end else if (move_en) begin
      if (up) begin
        if (row != LAST_ROW) w_row_next = row + ROW_ONE;
      end else if (down) begin
        if (row != '0) w_row_next = row - ROW_ONE;
      end else if (left) begin
        if (col != LAST_COL) w_col_next = col + COL_ONE;
      end else if (right) begin
        if (col != '0) w_col_next = col - COL_ONE;
      end
    end
  end

  // Position register; reset parks the frog on the start cell.
  always_ff @(posedge clk) begin
    if (reset) begin
      row <= '0;
      col <= START_C;
    end else begin
      row <= w_row_next;
      col <= w_col_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/frog_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : frog_ctrl                                                 |
// | Brief  : Player-side controller. Owns the frog position, detects   |
// |          collisions against the packed car lanes and tracks game   |
// |          state, lives and score for the LED matrix / HEX display.  |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
module frog_ctrl
  import frogger_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int ROWS       = ROWS_DEF,
  parameter int START_COL  = 7,
  parameter int LIVES      = 3,
  parameter int HIT_CYCLES = 50,
  parameter int SCORE_W    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    up,
  input  logic                    down,
  input  logic                    left,
  input  logic                    right,
  input  logic [ROWS*N-1:0]       lanes,
  output logic [$clog2(ROWS)-1:0] frog_row,
  output logic [$clog2(N)-1:0]    frog_col,
  output logic                    hit_flash,
  output logic                    game_over,
  output logic [LIVES_W-1:0]      lives,
  output logic [SCORE_W-1:0]      score
);

  localparam int RW = $clog2(ROWS);
  localparam int IW = $clog2(ROWS * N);
  // One extra value of headroom keeps the width non-zero for HIT_CYCLES=1.
  localparam int HW = $clog2(HIT_CYCLES + 1);

  localparam logic [RW-1:0]      LAST_ROW   = RW'(ROWS - 1);
  localparam logic [HW-1:0]      HIT_LAST   = HW'(HIT_CYCLES - 1);
  localparam logic [HW-1:0]      HIT_ONE    = HW'(1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

  game_state_t          r_state;
  game_state_t          w_state_next;
  logic [HW-1:0]        r_hit_cnt;
  logic [HW-1:0]        w_hit_cnt_next;
  logic [LIVES_W-1:0]   w_lives_next;
  logic [SCORE_W-1:0]   w_score_next;
  logic                 w_load_start;
  logic                 w_move_en;
  logic [IW-1:0]        w_cell_idx;
  logic                 w_safe_row;
  logic                 w_collide;
  logic                 w_goal;

  // Lane bit under the frog, computed from the registered position.
  assign w_cell_idx = IW'(frog_row) * IW'(N) + IW'(frog_col);
  assign w_safe_row = (frog_row == '0) || (frog_row == LAST_ROW);
  assign w_collide  = !w_safe_row && lanes[w_cell_idx];
  assign w_goal     = (frog_row == LAST_ROW);

  frog_pos #(
    .N         (N),
    .ROWS      (ROWS),
    .START_COL (START_COL)
  ) u_frog_pos (
    .clk        (clk),
    .reset      (reset),
    .load_start (w_load_start),
    .move_en    (w_move_en),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .row        (frog_row),
    .col        (frog_col)
  );

  // Next state, lives, score, HIT counter and position control.
  // In PLAY a collision beats a goal, which beats a move.
  always_comb begin
    w_state_next   = r_state;
    w_hit_cnt_next = r_hit_cnt;
    w_lives_next   = lives;
    w_score_next   = score;
    w_load_start   = 1'b0;
    w_move_en      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = PLAY;
      end
      PLAY: begin
        if (w_collide) begin
          w_lives_next   = lives - LIVES_ONE;
          w_hit_cnt_next = '0;
          w_state_next   = HIT;
        end else if (w_goal) begin
          if (score != SCORE_MAX) w_score_next = score + SCORE_ONE;
          w_load_start = 1'b1;
        end else begin
          w_move_en = 1'b1;
        end
      end
      HIT: begin
        if (r_hit_cnt == HIT_LAST) begin
          if (lives == '0) begin
            w_state_next = OVER;
          end else begin
            w_state_next = PLAY;
            w_load_start = 1'b1;
          end
        end else begin
          w_hit_cnt_next = r_hit_cnt + HIT_ONE;
        end
      end
      OVER: begin
        if (start) begin
          w_state_next = PLAY;
          w_lives_next = LIVES_INIT;
          w_score_next = '0;
          w_load_start = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State register and HIT countdown; reset kills any countdown in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_hit_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_hit_cnt <= w_hit_cnt_next;
    end
  end

  // Registered game outputs; flags are decoded from the next state so they
  // line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      lives     <= LIVES_INIT;
      score     <= '0;
      hit_flash <= 1'b0;
      game_over <= 1'b0;
    end else begin
      lives     <= w_lives_next;
      score     <= w_score_next;
      hit_flash <= (w_state_next == HIT);
      game_over <= (w_state_next == OVER);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frog_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_frog_ctrl                                              |
// | Brief  : Self-checking bench for frog_ctrl against a game-level    |
// |          reference model; directed scenarios then random play.     |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
module tb_frog_ctrl;

  localparam int N          = 16;
  localparam int ROWS       = 8;
  localparam int START_COL  = 7;
  localparam int LIVES      = 3;
  localparam int HIT_CYCLES = 50;
  localparam int SCORE_W    = 2;
  localparam int SCORE_MAX  = (1 << SCORE_W) - 1;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic                up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic [ROWS*N-1:0]   lanes = '0;
  logic [2:0]          frog_row;
  logic [3:0]          frog_col;
  logic                hit_flash;
  logic                game_over;
  logic [2:0]          lives;
  logic [SCORE_W-1:0]  score;

  frog_ctrl #(
    .N          (N),
    .ROWS       (ROWS),
    .START_COL  (START_COL),
    .LIVES      (LIVES),
    .HIT_CYCLES (HIT_CYCLES),
    .SCORE_W    (SCORE_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .lanes     (lanes),
    .frog_row  (frog_row),
    .frog_col  (frog_col),
    .hit_flash (hit_flash),
    .game_over (game_over),
    .lives     (lives),
    .score     (score)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Game-level reference: mode, frog cell, lives, score, HIT cycles elapsed.
  typedef enum {M_IDLE, M_PLAY, M_HIT, M_OVER} mode_t;
  mode_t m_mode;
  int    m_row, m_col, m_lives, m_score, m_hit_time;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit st, input bit u, input bit d,
                            input bit l, input bit r, input logic [ROWS*N-1:0] ln);
    if (rst) begin
      m_mode = M_IDLE; m_row = 0; m_col = START_COL;
      m_lives = LIVES; m_score = 0; m_hit_time = 0;
      return;
    end
    case (m_mode)
      M_IDLE: if (st) m_mode = M_PLAY;
      M_PLAY: begin
        if (m_row > 0 && m_row < ROWS - 1 && ln[m_row * N + m_col] === 1'b1) begin
          m_lives = m_lives - 1;
          m_hit_time = 0;
          m_mode = M_HIT;
        end else if (m_row == ROWS - 1) begin
          m_score = (m_score + 1 > SCORE_MAX) ? SCORE_MAX : m_score + 1;
          m_row = 0; m_col = START_COL;
        end else if (u) m_row = (m_row + 1 > ROWS - 1) ? m_row : m_row + 1;
        else if (d)     m_row = (m_row == 0) ? 0 : m_row - 1;
        else if (l)     m_col = (m_col + 1 > N - 1) ? m_col : m_col + 1;
        else if (r)     m_col = (m_col == 0) ? 0 : m_col - 1;
      end
      M_HIT: begin
        m_hit_time = m_hit_time + 1;
        if (m_hit_time == HIT_CYCLES) begin
          if (m_lives == 0) m_mode = M_OVER;
          else begin
            m_mode = M_PLAY; m_row = 0; m_col = START_COL;
          end
        end
      end
      M_OVER: if (st) begin
        m_mode = M_PLAY; m_lives = LIVES; m_score = 0;
        m_row = 0; m_col = START_COL;
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  // One clock: drive on the falling edge, advance the model, check after rise.
  task automatic cyc(input bit rst, input bit st, input bit u, input bit d,
                     input bit l, input bit r, input logic [ROWS*N-1:0] ln);
    @(negedge clk);
    reset = rst; start = st; up = u; down = d; left = l; right = r; lanes = ln;
    model_step(rst, st, u, d, l, r, ln);
    @(posedge clk);
    #1;
    check("frog_row",  int'(frog_row),  m_row);
    check("frog_col",  int'(frog_col),  m_col);
    check("hit_flash", int'(hit_flash), (m_mode == M_HIT)  ? 1 : 0);
    check("game_over", int'(game_over), (m_mode == M_OVER) ? 1 : 0);
    check("lives",     int'(lives),     m_lives);
    check("score",     int'(score),     m_score);
  endtask

  logic [ROWS*N-1:0] z;
  logic [ROWS*N-1:0] banks;
  logic [ROWS*N-1:0] ln;
  logic [N-1:0]      word;

  initial begin
    z = '0;
    banks = '0;
    banks[0 +: N] = '1;
    banks[(ROWS-1)*N +: N] = '1;

    // Reset, start, three steps up on an empty road.
    cyc(1, 0, 0, 0, 0, 0, z);
    cyc(0, 0, 1, 0, 0, 0, z);          // moves ignored in IDLE
    cyc(0, 1, 0, 0, 0, 0, z);
    repeat (3) cyc(0, 0, 1, 0, 0, 0, z);
    check("row_after_3_ups", int'(frog_row), 3);

    // Edge clamping on row 0 and both column edges; simultaneous pulses.
    repeat (4) cyc(0, 0, 0, 1, 0, 0, z);
    repeat (9) cyc(0, 0, 0, 0, 0, 1, z);
    check("col_clamp_low", int'(frog_col), 0);
    repeat (17) cyc(0, 0, 0, 0, 1, 0, z);
    check("col_clamp_high", int'(frog_col), N - 1);
    cyc(0, 0, 0, 1, 1, 1, z);          // down wins, clamps at row 0
    repeat (8) cyc(0, 0, 0, 0, 0, 1, z);

    // Collision at (2,7) with an up pulse in the same cycle, then HIT.
    repeat (2) cyc(0, 0, 1, 0, 0, 0, z);
    ln = z; ln[2*N + 7] = 1'b1;
    cyc(0, 0, 1, 0, 0, 0, ln);
    check("hit_lives", int'(lives), 2);
    repeat (HIT_CYCLES) cyc(0, 1, $urandom_range(0, 1), 0, 1, 0, z);

    // Five crossings over car-filled banks: score saturates at 3.
    repeat (5) begin
      repeat (ROWS) cyc(0, 0, 1, 0, 0, 0, banks);
    end
    check("score_saturated", int'(score), SCORE_MAX);

    // Lose remaining lives on row 1, then game over and restart.
    repeat (2) begin
      cyc(0, 0, 1, 0, 0, 0, z);
      ln = z; ln[1*N + 7] = 1'b1;
      cyc(0, 0, 0, 0, 0, 0, ln);
      repeat (HIT_CYCLES) cyc(0, 0, 1, 0, 0, 0, z);
    end
    repeat (3) cyc(0, 0, 1, 0, 1, 0, z);
    check("over_flag", int'(game_over), 1);
    cyc(0, 1, 0, 0, 0, 0, z);

    // Reset in the middle of a HIT countdown.
    cyc(0, 0, 1, 0, 0, 0, z);
    ln = z; ln[1*N + 7] = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, ln);
    repeat (20) cyc(0, 0, 0, 0, 0, 0, z);
    cyc(1, 0, 0, 0, 0, 0, z);
    check("reset_mid_hit_flash", int'(hit_flash), 0);
    cyc(0, 1, 0, 0, 0, 0, z);

    // Random play: empty road, sparse traffic, or traffic on banks only.
    begin
      int mode;
      bit u, d, l, r, st, rs;
      mode = 0;
      for (int i = 0; i < 3000; i++) begin
        if (i % 40 == 0) mode = $urandom_range(0, 2);
        rs = ($urandom_range(0, 499) == 0);
        st = ($urandom_range(0, 19) == 0);
        u  = ($urandom_range(0, 99) < ((mode == 0) ? 25 : 60));
        d  = ($urandom_range(0, 3) == 0);
        l  = ($urandom_range(0, 3) == 0);
        r  = ($urandom_range(0, 3) == 0);
        ln = z;
        if (mode == 1) begin
          for (int k = 0; k < ROWS; k++) begin
            word = N'($urandom & $urandom & $urandom);
            ln[k*N +: N] = word;
          end
        end else if (mode == 2) begin
          ln = banks;
        end
        cyc(rs, st, u, d, l, r, ln);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
